// File: rtl/alu_rotate_seq_if.sv
// +-----------------------------------------------------------------------+
// | alu_rotate_seq_if                                                     |
// | Request/result bundle for the sequential rotate/shift unit.           |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

interface alu_rotate_seq_if #(
  parameter int WIDTH = 8
);
  localparam int AMT_W = $clog2(WIDTH);

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [AMT_W-1:0] amt;
  logic [WIDTH-1:0] r;
  logic             carry;
  logic             busy;
  logic             done;

  modport master (
    output start, op, a, amt,
    input  r, carry, busy, done
  );

  modport slave (
    input  start, op, a, amt,
    output r, carry, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/alu_rotate_seq.sv
// +-----------------------------------------------------------------------+
// | alu_rotate_seq                                                        |
// | Bit-serial ROL/ROR/SHL/SHR unit, one bit per clock, start/done.       |
// | Optional build macro: ALU_ROT_CARRY_EN (carry-out flop).              |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module alu_rotate_seq #(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_rotate_seq_if.slave  bus
);

  localparam logic [1:0] c_ROL = 2'b00;
  localparam logic [1:0] c_ROR = 2'b01;
  localparam logic [1:0] c_SHL = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_work,  w_work_nxt;
  logic [AMT_W-1:0] r_cnt,   w_cnt_nxt;
  logic [1:0]       r_op,    w_op_nxt;
  logic [1:0]       w_step_op;
  logic [WIDTH-1:0] w_step_in;

  function automatic logic [WIDTH-1:0] step_val(input logic [1:0] o, input logic [WIDTH-1:0] v);
    case (o)
      c_ROL:   step_val = {v[WIDTH-2:0], v[WIDTH-1]};
      c_ROR:   step_val = {v[0], v[WIDTH-1:1]};
      c_SHL:   step_val = {v[WIDTH-2:0], 1'b0};
      default: step_val = {1'b0, v[WIDTH-1:1]};
    endcase
  endfunction

`ifdef ALU_ROT_CARRY_EN
  logic r_carry, w_carry_nxt;
  // Left-going modes lose the MSB, right-going modes lose the LSB.
  wire  w_step_bit = w_step_op[0] ? w_step_in[0] : w_step_in[WIDTH-1];
`endif

  // The accepting edge already performs the first step so that an
  // amount of n finishes in max(n,1) cycles; cnt holds steps still to go.
  always_comb begin
    w_state_nxt = r_state;
    w_work_nxt  = r_work;
    w_cnt_nxt   = r_cnt;
    w_op_nxt    = r_op;
    w_step_op   = r_op;
    w_step_in   = r_work;
`ifdef ALU_ROT_CARRY_EN
    w_carry_nxt = r_carry;
`endif
    if (r_state == S_IDLE) begin
      w_step_op = bus.op;
      w_step_in = bus.a;
    end
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_op_nxt = bus.op;
          if (bus.amt == '0) begin
            w_work_nxt  = bus.a;
            w_cnt_nxt   = '0;
            w_state_nxt = S_DONE;
`ifdef ALU_ROT_CARRY_EN
            w_carry_nxt = 1'b0;
`endif
          end else begin
            w_work_nxt  = step_val(w_step_op, w_step_in);
            w_cnt_nxt   = bus.amt - AMT_W'(1);
            w_state_nxt = (bus.amt == AMT_W'(1)) ? S_DONE : S_SHIFT;
`ifdef ALU_ROT_CARRY_EN
            w_carry_nxt = w_step_bit;
`endif
          end
        end
      end
      S_SHIFT: begin
        w_work_nxt = step_val(w_step_op, w_step_in);
        w_cnt_nxt  = r_cnt - AMT_W'(1);
`ifdef ALU_ROT_CARRY_EN
        w_carry_nxt = w_step_bit;
`endif
        if (r_cnt == AMT_W'(1)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_work  <= '0;
      r_cnt   <= '0;
      r_op    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_work  <= w_work_nxt;
      r_cnt   <= w_cnt_nxt;
      r_op    <= w_op_nxt;
    end
  end

`ifdef ALU_ROT_CARRY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_carry <= 1'b0;
    end else begin
      r_carry <= w_carry_nxt;
    end
  end
  assign bus.carry = r_carry;
`else
  assign bus.carry = 1'b0;
`endif

  assign bus.r    = r_work;
  assign bus.busy = (r_state != S_IDLE);
  assign bus.done = (r_state == S_DONE);

endmodule

`default_nettype wire
